// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch (I) and load/store (D), D first; ARB_FAIR_EN adds I anti-starvation.
// Ack is combinational with bus_ack_i (1-cycle minimum) or a timeout error; requesters stall until acked.
module mem_bus_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int TIMEOUT      = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req_i,
   input  logic [ADDR_W-1:0]   i_addr_i,
   output logic [DATA_W-1:0]   i_rdata_o,
   output logic                i_ack_o,
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W/8-1:0] d_sel_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                d_ack_o,
   output logic                err_o,
   output logic                stall_if_o,
   output logic                stall_mem_o,
   output logic                bus_cyc_o,
   output logic                bus_stb_o,
   output logic                bus_we_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [DATA_W/8-1:0] bus_sel_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   input  logic [DATA_W-1:0]   bus_rdata_i,
   input  logic                bus_ack_i
);

   localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

   state_t     state, state_nxt;
   logic [7:0] tmo_cnt;
   logic       tmo_hit;
   logic       force_i;

   assign tmo_hit     = (tmo_cnt == TMO_LIM);
   assign stall_if_o  = i_req_i & ~i_ack_o;
   assign stall_mem_o = d_req_i & ~d_ack_o;

`ifdef ARB_FAIR_EN
   localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
   logic [7:0] starve_cnt;

   assign force_i = i_req_i && (starve_cnt == STARVE_LIM);

   // Counts back-to-back D wins only while I is actually waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (state_nxt == IBUS || !i_req_i)
            starve_cnt <= '0;
         else if (state_nxt == DBUS)
            starve_cnt <= starve_cnt + 8'd1;
      end
   end
`else
   // Strict D priority: never force an I grant.
   assign force_i = (STARVE_LIMIT < 0);
`endif

   always_comb begin
      state_nxt = state;
      i_ack_o   = 1'b0;
      d_ack_o   = 1'b0;
      err_o     = 1'b0;
      i_rdata_o = '0;
      d_rdata_o = '0;
      case (state)
         IDLE: begin
            if (d_req_i && !force_i)
               state_nxt = DBUS;
            else if (i_req_i)
               state_nxt = IBUS;
         end
         IBUS: begin
            if (bus_ack_i) begin
               i_ack_o   = 1'b1;
               i_rdata_o = bus_rdata_i;
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               i_ack_o   = 1'b1;
               err_o     = 1'b1;
               state_nxt = IDLE;
            end
         end
         DBUS: begin
            if (bus_ack_i) begin
               d_ack_o   = 1'b1;
               d_rdata_o = bus_rdata_i;
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               d_ack_o   = 1'b1;
               err_o     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= (state == IDLE) ? 8'd0 : tmo_cnt + 8'd1;
      end
   end

   // Bus fields are captured at grant and held until the transaction ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_cyc_o   <= 1'b0;
         bus_stb_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= '0;
         bus_wdata_o <= '0;
      end else if (state == IDLE && state_nxt == DBUS) begin
         bus_cyc_o   <= 1'b1;
         bus_stb_o   <= 1'b1;
         bus_we_o    <= d_we_i;
         bus_addr_o  <= d_addr_i;
         bus_sel_o   <= d_sel_i;
         bus_wdata_o <= d_wdata_i;
      end else if (state == IDLE && state_nxt == IBUS) begin
         bus_cyc_o   <= 1'b1;
         bus_stb_o   <= 1'b1;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= i_addr_i;
         bus_sel_o   <= '1;
         bus_wdata_o <= '0;
      end else if (state != IDLE && state_nxt == IDLE) begin
         bus_cyc_o   <= 1'b0;
         bus_stb_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= '0;
         bus_wdata_o <= '0;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed requests, scripted bus slave, scoreboard of expected acks.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_i, d_req_i, d_we_i;
   logic [31:0] i_addr_i, d_addr_i, d_wdata_i;
   logic [3:0]  d_sel_i;
   logic [31:0] i_rdata_o, d_rdata_o;
   logic        i_ack_o, d_ack_o, err_o, stall_if_o, stall_mem_o;
   logic        bus_cyc_o, bus_stb_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
   logic [3:0]  bus_sel_o;
   logic        bus_ack_i;

   logic [31:0] bus_data;
   int          bus_wait;
   int          stb_cnt;
   int          n_checks = 0;
   int          n_fail   = 0;

   typedef struct {
      bit          d_side;
      logic [31:0] data;
      bit          err;
   } exp_t;
   exp_t sb_q[$];

   assign bus_rdata_i = bus_data;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ack_o(i_ack_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i),
      .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .err_o(err_o),
      .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
      .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
      .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input bit d_side, input logic [31:0] data, input bit err);
      exp_t e;
      e.d_side = d_side;
      e.data   = data;
      e.err    = err;
      sb_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit d_side, input string nm);
      bit got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (d_side ? d_ack_o : i_ack_o) got = 1'b1;
      end
      check(nm, got, 1);
   endtask

   // Bus slave: acks bus_wait cycles after strobe rises; negative means never.
   initial begin
      bus_ack_i = 1'b0;
      stb_cnt   = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bus_stb_o) begin
            bus_ack_i = (stb_cnt == bus_wait);
            stb_cnt++;
         end else begin
            bus_ack_i = 1'b0;
            stb_cnt   = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (i_ack_o || d_ack_o) begin
         check("one_ack_only", {i_ack_o, d_ack_o} == 2'b11, 0);
         if (sb_q.size() == 0) begin
            check("unexpected_ack", {i_ack_o, d_ack_o}, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("ack_side", d_ack_o, e.d_side);
            check("ack_rdata", d_ack_o ? d_rdata_o : i_rdata_o, e.data);
            check("ack_err", err_o, e.err);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      i_req_i = 0; d_req_i = 0; d_we_i = 0;
      i_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; d_sel_i = 0;
      bus_wait = 0; bus_data = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_bus", {bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o}, 0);
      check("rst_acks", {i_ack_o, d_ack_o, err_o, i_rdata_o, d_rdata_o}, 0);
      cyc();
      rst = 1'b0;
      cyc();

      // Single fetch, zero-wait bus
      bus_wait = 0; bus_data = 32'h3401_1100; i_addr_i = 32'h100; i_req_i = 1;
      push(0, 32'h3401_1100, 0);
      @(negedge clk);
      check("f_c0_stb", bus_stb_o, 0);
      check("f_c0_stall_if", stall_if_o, 1);
      cyc();
      @(negedge clk);
      check("f_c1_addr", bus_addr_o, 32'h100);
      check("f_c1_sel", bus_sel_o, 4'hF);
      check("f_c1_stb_we", {bus_cyc_o, bus_stb_o, bus_we_o}, 3'b110);
      check("f_c1_ack", i_ack_o, 1);
      cyc();
      i_req_i = 0;
      @(negedge clk);
      check("f_c2_stb", bus_stb_o, 0);

      // Byte store with 3 wait cycles
      cyc();
      bus_wait = 3; bus_data = 32'h5555_0000;
      d_we_i = 1; d_addr_i = 32'h8; d_sel_i = 4'h2; d_wdata_i = 32'h0000_AB00; d_req_i = 1;
      push(1, 32'h5555_0000, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         @(negedge clk);
         check("st_fields", {bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o},
               {1'b1, 1'b1, 32'h8, 4'h2, 32'h0000_AB00});
         check("st_stall_mem", stall_mem_o, k < 4);
         check("st_ack", d_ack_o, k == 4);
      end
      cyc();
      d_req_i = 0;
      @(negedge clk);
      check("st_done", {bus_stb_o, d_ack_o}, 0);

      // Simultaneous I and D: D first, I after one IDLE cycle
      cyc();
      bus_wait = 1; bus_data = 32'h1111_2222;
      d_we_i = 0; d_addr_i = 32'h20; d_sel_i = 4'hF; i_addr_i = 32'h104;
      d_req_i = 1; i_req_i = 1;
      push(1, 32'h1111_2222, 0);
      push(0, 32'h1111_2222, 0);
      n = 0;
      for (int k = 0; k < 20 && n == 0; k++) begin
         @(negedge clk);
         check("sim_stall_if", stall_if_o, 1);
         if (d_ack_o) n = 1;
      end
      check("sim_d_acked", n, 1);
      cyc();
      d_req_i = 0;
      @(negedge clk);
      check("sim_idle_gap", {bus_stb_o, stall_if_o}, 2'b01);
      cyc();
      @(negedge clk);
      check("sim_i_on_bus", {bus_stb_o, bus_we_o, bus_addr_o}, {1'b1, 1'b0, 32'h104});
      wait_ack(0, "sim_i_acked");
      cyc();
      i_req_i = 0;

      // Timeout: bus never acks
      cyc();
      bus_wait = -1; bus_data = 32'hDEAD_BEEF;
      d_we_i = 0; d_addr_i = 32'h40; d_req_i = 1;
      push(1, 32'h0, 1);
      for (int k = 1; k <= 16; k++) begin
         cyc();
         @(negedge clk);
         check("to_stb", bus_stb_o, 1);
         check("to_ack_err", {d_ack_o, err_o}, (k == 16) ? 2'b11 : 2'b00);
      end
      cyc();
      d_req_i = 0;
      @(negedge clk);
      check("to_idle", {bus_stb_o, d_ack_o, err_o}, 0);

      // Reset during a 5-wait fetch
      cyc();
      bus_wait = 5; bus_data = 32'h0BAD_F00D; i_addr_i = 32'h200; i_req_i = 1;
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      check("rst_mid_bus", {bus_cyc_o, bus_stb_o, bus_addr_o, bus_sel_o}, 0);
      check("rst_mid_acks", {i_ack_o, err_o, i_rdata_o}, 0);
      check("rst_mid_stall", stall_if_o, 1);
      cyc();
      @(negedge clk);
      check("rst_hold", {bus_stb_o, i_ack_o}, 0);
      cyc();
      rst = 1'b0;
      bus_wait = 0;
      push(0, 32'h0BAD_F00D, 0);
      @(negedge clk);
      check("rst_rel_idle", bus_stb_o, 0);
      cyc();
      @(negedge clk);
      check("rst_restart", {bus_stb_o, bus_addr_o}, {1'b1, 32'h200});
      check("rst_restart_ack", i_ack_o, 1);
      cyc();
      i_req_i = 0;

      // Both held continuously: grant order
      cyc();
      bus_wait = 0; bus_data = 32'h600D_0000;
      i_addr_i = 32'h300; d_addr_i = 32'h400; d_we_i = 0;
`ifdef ARB_FAIR_EN
      push(1, bus_data, 0); push(1, bus_data, 0); push(1, bus_data, 0);
      push(1, bus_data, 0); push(0, bus_data, 0); push(1, bus_data, 0);
`else
      for (int k = 0; k < 6; k++) push(1, bus_data, 0);
`endif
      i_req_i = 1; d_req_i = 1;
      n = 0;
      for (int k = 0; k < 60 && n < 6; k++) begin
         @(negedge clk);
         if (i_ack_o || d_ack_o) n++;
      end
      check("fair_grants", n, 6);
      cyc();
      i_req_i = 0; d_req_i = 0;

      repeat (3) cyc();
      check("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares the single external memory bus between two requesters: instruction fetch (I-side, read-only) and load/store (D-side, read/write).
- Sits between the `pc_reg`/`id` front end, the memory-access stage and the memory bus.
- Arbitrates, launches one bus transaction at a time, returns data and ack to the winner, and raises per-side stall requests for the pipeline controller.
- Bounds every bus transaction with a timeout.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 15, max cycles waiting for `bus_ack_i` before abort (1..255)
- `STARVE_LIMIT`, 4, consecutive D grants before forced I grant (only with `ARB_FAIR_EN`)

Ports:
- `clk` in 1, clock, rising edge
- `rst` in 1, asynchronous active-high reset
- `i_req_i` in 1, fetch request, level, held until `i_ack_o`
- `i_addr_i` in ADDR_W, fetch address, stable while `i_req_i`
- `i_rdata_o` out DATA_W, fetch data, valid with `i_ack_o`
- `i_ack_o` out 1, fetch complete, one-cycle pulse
- `d_req_i` in 1, load/store request, level, held until `d_ack_o`
- `d_we_i` in 1, 1 = store
- `d_addr_i` in ADDR_W, data address
- `d_sel_i` in DATA_W/8, byte enables
- `d_wdata_i` in DATA_W, store data
- `d_rdata_o` out DATA_W, load data, valid with `d_ack_o`
- `d_ack_o` out 1, load/store complete, one-cycle pulse
- `err_o` out 1, accompanies an ack when the transaction timed out
- `stall_if_o` out 1, `i_req_i & ~i_ack_o`
- `stall_mem_o` out 1, `d_req_i & ~d_ack_o`
- `bus_cyc_o`, `bus_stb_o` out 1, registered, high for the whole transaction
- `bus_we_o` out 1, registered
- `bus_addr_o` out ADDR_W, registered
- `bus_sel_o` out DATA_W/8, registered
- `bus_wdata_o` out DATA_W, registered
- `bus_rdata_i` in DATA_W, read data
- `bus_ack_i` in 1, bus completion

## Operation
- States:
  - IDLE: no transaction in progress.
  - IBUS: fetch transaction on the bus.
  - DBUS: load/store transaction on the bus.
- IDLE:
  - If `d_req_i`: go to DBUS. Otherwise, if `i_req_i`: go to IBUS.
  - Default priority is D over I.
  - On entry to either bus state, register the winning request's address, we, sel and wdata onto the bus, and set `bus_cyc_o`/`bus_stb_o`.
- IBUS fields: `bus_we_o`=0, `bus_sel_o`=all ones, `bus_wdata_o`=0.
- IBUS/DBUS, on `bus_ack_i`:
  - Winner's ack = 1 combinationally in the same cycle.
  - Winner's rdata = `bus_rdata_i` in the same cycle.
  - Next state IDLE; bus outputs clear at that edge.
- Timeout counter: cleared on entry to a bus state, increments every cycle without `bus_ack_i`. When it reaches `TIMEOUT`:
  - Winner's ack = 1, `err_o` = 1, rdata = 0.
  - Next state IDLE.
- `bus_ack_i` in IDLE is ignored. `i_ack_o`, `d_ack_o` and `err_o` are never asserted in IDLE.
- Non-winner ack is always 0; a request that drops mid-transaction does not cancel the bus cycle.
- Reset at any point, including mid-transaction:
  - State IDLE, counters 0.
  - All outputs 0: bus outputs, acks, `err_o`, rdata.
  - The outstanding transaction is dropped with no ack.
  - Stall outputs follow requests combinationally.

## Timing
- Cycle 0: request is high in IDLE.
- Cycle 1: `bus_stb_o`=1. `bus_ack_i` is permitted this cycle; an ack here gives requester ack in cycle 1, i.e. 1-cycle minimum latency.
- Back-to-back transactions always have exactly one IDLE cycle between them.
  - The requester samples the ack at the edge ending the ack cycle and may deassert or change the request in the next (IDLE) cycle.
- The timeout ack occurs in cycle `TIMEOUT`+1 after IDLE when no `bus_ack_i` arrives.
- Simultaneous `i_req_i` and `d_req_i` in IDLE: D wins, I stalls through the D transaction and gains the bus after the IDLE cycle if D has dropped.

## Configuration
- `ARB_FAIR_EN` defined:
  - A 3-bit-or-wider counter counts consecutive D grants made while `i_req_i` was high. It is reset by any I grant or by an IDLE arbitration with `i_req_i` low.
  - When the count equals `STARVE_LIMIT`, the next IDLE arbitration grants I even if `d_req_i` is high.
- Not defined: strict D priority; no counter logic. I may starve indefinitely.

## Test plan
- Single fetch, `i_addr_i`=0x0000_0100, bus acks in cycle 1 with 0x3401_1100:
  - `bus_addr_o`=0x100, `bus_sel_o`=0xF in cycle 1.
  - `i_ack_o`=1 and `i_rdata_o`=0x3401_1100 in cycle 1.
  - `bus_stb_o`=0 in cycle 2.
- Store byte: `d_addr_i`=0x8, `d_sel_i`=0x2, `d_wdata_i`=0x0000_AB00, ack after 3 wait cycles:
  - `bus_we_o`=1 and fields stable for 4 cycles.
  - `d_ack_o` pulses once; `stall_mem_o` is high until the ack.
- Simultaneous I and D requests:
  - DBUS first; `stall_if_o` is high throughout.
  - IBUS starts after one IDLE cycle once `d_req_i` drops.
- `TIMEOUT`=15, bus never acks: `d_ack_o`=1, `err_o`=1, `d_rdata_o`=0 in cycle 16; state then IDLE.
- Assert `rst` in cycle 2 of a 5-wait-cycle fetch:
  - All outputs are 0 immediately; no `i_ack_o`.
  - After release, the still-held `i_req_i` restarts from IDLE.
- `ARB_FAIR_EN`, `STARVE_LIMIT`=4, D and I requests held continuously: grant order D,D,D,D,I,D…; without the macro, I is never granted.
